pipe_hazard_ctrl: RTL

Hazard and pipeline-sequencing controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Generates stall, flush and forwarding selects for the decode stage (ID-stage branch compare forwarding, EX flush) and the EX operand muxes.
- A small FSM freezes the pipeline while data memory is not ready, with a timeout watchdog.
- Sits beside the stage modules in the top-level core and is driven purely by stage register addresses and control bits.

---
 rtl/pipe_hazard_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/forward control and data-memory freeze FSM for a 5-stage MIPS pipeline.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined. Revision 1.0.
`default_nettype none

module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_branch,
  input  logic             id_jump,
  input  logic             id_pc_src,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       ex_reg_wr_addr,
  input  logic             ex_reg_wr_en,
  input  logic             ex_mem_to_reg,
  input  logic [4:0]       mem_reg_wr_addr,
  input  logic             mem_reg_wr_en,
  input  logic             mem_mem_to_reg,
  input  logic [4:0]       wb_reg_wr_addr,
  input  logic             wb_reg_wr_en,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             flush_wb,
  output logic             forwardA_id,
  output logic             forwardB_id,
  output logic [1:0]       forwardA_ex,
  output logic [1:0]       forwardB_ex,
  output logic             mem_err,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
);

  localparam int TMR_W = $clog2(MEM_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             mem_err_q, mem_err_d;

  logic freeze;
  logic err_cycle;

  // Register matches: $0 and disabled writers never match.
  logic mem_hit_ex_rs, mem_hit_ex_rt, wb_hit_ex_rs, wb_hit_ex_rt;
  logic mem_hit_id_rs, mem_hit_id_rt, ex_hit_id_rs, ex_hit_id_rt;
  logic lw_stall, br_stall;

  always_comb begin
    mem_hit_ex_rs = mem_reg_wr_en && (mem_reg_wr_addr != 5'd0) && (mem_reg_wr_addr == ex_rs);
    mem_hit_ex_rt = mem_reg_wr_en && (mem_reg_wr_addr != 5'd0) && (mem_reg_wr_addr == ex_rt);
    wb_hit_ex_rs  = wb_reg_wr_en  && (wb_reg_wr_addr  != 5'd0) && (wb_reg_wr_addr  == ex_rs);
    wb_hit_ex_rt  = wb_reg_wr_en  && (wb_reg_wr_addr  != 5'd0) && (wb_reg_wr_addr  == ex_rt);
    mem_hit_id_rs = mem_reg_wr_en && (mem_reg_wr_addr != 5'd0) && (mem_reg_wr_addr == id_rs);
    mem_hit_id_rt = mem_reg_wr_en && (mem_reg_wr_addr != 5'd0) && (mem_reg_wr_addr == id_rt);
    ex_hit_id_rs  = ex_reg_wr_en  && (ex_reg_wr_addr  != 5'd0) && (ex_reg_wr_addr  == id_rs);
    ex_hit_id_rt  = ex_reg_wr_en  && (ex_reg_wr_addr  != 5'd0) && (ex_reg_wr_addr  == id_rt);
  end

  always_comb begin
    forwardA_ex = 2'b00;
    forwardB_ex = 2'b00;
    if (mem_hit_ex_rs)     forwardA_ex = 2'b10;
    else if (wb_hit_ex_rs) forwardA_ex = 2'b01;
    if (mem_hit_ex_rt)     forwardB_ex = 2'b10;
    else if (wb_hit_ex_rt) forwardB_ex = 2'b01;
    forwardA_id = mem_hit_id_rs;
    forwardB_id = mem_hit_id_rt;
  end

  // A branch compares in ID, so it must wait for an EX result and for a load still in MEM.
  always_comb begin
    lw_stall = ex_mem_to_reg && (ex_hit_id_rs || ex_hit_id_rt);
    br_stall = id_branch && ((ex_hit_id_rs || ex_hit_id_rt) ||
                             (mem_mem_to_reg && (mem_hit_id_rs || mem_hit_id_rt)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_RUN;
      timer_q   <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    mem_err_d = mem_err_q;
    freeze    = 1'b0;
    err_cycle = 1'b0;
    case (state_q)
      S_RUN: begin
        if (dmem_req && !dmem_ready) begin
          freeze  = 1'b1;
          state_d = S_WAIT;
          timer_d = '0;
        end
      end
      S_WAIT: begin
        freeze = 1'b1;
        if (dmem_ready) begin
          state_d = S_RUN;
        end else if (timer_q == TMR_LAST) begin
          state_d = S_ERR;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_ERR: begin
        err_cycle = 1'b1;
        mem_err_d = 1'b1;
        state_d   = S_RUN;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  // While reset is held every stall and flush is forced low, even if dmem_req is pending.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    flush_wb  = 1'b0;
    if (reset) begin
      if (freeze) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        stall_mem = 1'b1;
        flush_wb  = 1'b1;
      end else if (lw_stall || br_stall) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
      end else if (id_pc_src || id_jump) begin
        flush_id = 1'b1;
      end
      if (err_cycle) begin
        flush_wb = 1'b1;
      end
    end
  end

  assign mem_err = mem_err_q | err_cycle;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] perf_stall_cnt_q, perf_stall_cnt_d;
  logic [CNT_W-1:0] perf_flush_cnt_q, perf_flush_cnt_d;

  always_comb begin
    perf_stall_cnt_d = perf_stall_cnt_q;
    perf_flush_cnt_d = perf_flush_cnt_q;
    if (stall_if)             perf_stall_cnt_d = perf_stall_cnt_q + CNT_W'(1);
    if (flush_id || flush_ex) perf_flush_cnt_d = perf_flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cnt_q <= '0;
      perf_flush_cnt_q <= '0;
    end else begin
      perf_stall_cnt_q <= perf_stall_cnt_d;
      perf_flush_cnt_q <= perf_flush_cnt_d;
    end
  end

  assign perf_stall_cnt = perf_stall_cnt_q;
  assign perf_flush_cnt = perf_flush_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

`default_nettype wire
